// File: rtl/song_sequencer_pkg.sv
// rtl/song_sequencer_pkg.sv - shared constants, entry layout, FSM states and pitch decode
package song_sequencer_pkg;

  localparam int CLK_HZ_DEFAULT = 25000000;

  // Pitch codes: 1..8 select C4..C5, everything else is silence
  typedef enum logic [3:0] {
    PITCH_REST = 4'd0,
    PITCH_C4   = 4'd1,
    PITCH_D4   = 4'd2,
    PITCH_E4   = 4'd3,
    PITCH_F4   = 4'd4,
    PITCH_G4   = 4'd5,
    PITCH_A4   = 4'd6,
    PITCH_B4   = 4'd7,
    PITCH_C5   = 4'd8
  } pitch_t;

  // Song entry layout: [7:4] pitch code, [3:0] duration in ticks
  localparam int PITCH_LSB = 4;
  localparam int PITCH_W   = 4;
  localparam int DUR_LSB   = 0;
  localparam int DUR_W     = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_PLAY,
    ST_GAP
  } state_t;

  // C4 drives bit 7, C5 drives bit 0; rests and unused codes give no gate
  function automatic logic [7:0] pitch_onehot(input logic [3:0] code);
    logic [7:0] r;
    r = 8'h00;
    if (code >= PITCH_C4 && code <= PITCH_C5)
      r = 8'h80 >> (code - 4'(PITCH_C4));
    return r;
  endfunction

endpackage

// File: rtl/song_sequencer_if.sv
// rtl/song_sequencer_if.sv - song RAM write port bundle
interface song_sequencer_if #(
  parameter int ADDR_W = 3
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  modport master (output wr_en, output wr_addr, output wr_data);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/song_sequencer_tick_gen.sv
// rtl/song_sequencer_tick_gen.sv - duration tick divider with synchronous clear
module tick_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt;

  assign tick = (cnt == W'(DIV - 1));

  // Count 0..DIV-1; clear restarts the period so every note starts aligned
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clr || tick)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/song_sequencer.sv
// rtl/song_sequencer.sv - song RAM playback sequencer with live-switch passthrough
module song_sequencer
  import song_sequencer_pkg::*;
#(
  parameter int CLK_HZ    = CLK_HZ_DEFAULT,
  parameter int TICK_HZ   = 50,
  parameter int ADDR_W    = 3,
  parameter int GAP_TICKS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  input  logic [7:0]        sw,
  song_sequencer_if.slave   wr,
  output logic [7:0]        note_en,
  output logic              busy,
  output logic [ADDR_W-1:0] step,
  output logic              done
);
  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int SONG_LEN = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_STEP = ADDR_W'(SONG_LEN - 1);

  typedef logic [7:0] song_t [SONG_LEN];

  // Power-up melody: the scale C4..C5, four ticks per note
  function automatic song_t song_init();
    song_t s;
    for (int i = 0; i < SONG_LEN; i++)
      s[i] = {4'((i % 8) + 1), 4'd4};
    return s;
  endfunction

  song_t       mem = song_init();
  logic [7:0]  rdata;
  logic [3:0]  pitch, dur;

  state_t            state, nxt;
  logic [7:0]        n_note;
  logic [ADDR_W-1:0] n_step;
  logic [3:0]        rem, n_rem;
  logic              n_done, clr, tick, adv, fin;

  assign pitch = rdata[PITCH_LSB +: PITCH_W];
  assign dur   = rdata[DUR_LSB +: DUR_W];
  assign busy  = (state != ST_IDLE);

  // Song RAM: synchronous read of the current step, old data wins on a same-cycle write
  always_ff @(posedge clk) begin
    if (wr.wr_en)
      mem[wr.wr_addr] <= wr.wr_data;
    rdata <= mem[step];
  end

  tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .tick (tick)
  );

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      note_en <= 8'h00;
      step    <= '0;
      rem     <= 4'd0;
      done    <= 1'b0;
    end else begin
      state   <= nxt;
      note_en <= n_note;
      step    <= n_step;
      rem     <= n_rem;
      done    <= n_done;
    end
  end

  // Next-state and output logic; stop overrides everything once playback is running
  always_comb begin
    nxt    = state;
    n_note = note_en;
    n_step = step;
    n_rem  = rem;
    n_done = 1'b0;
    clr    = (state != ST_PLAY) && (state != ST_GAP);
    adv    = 1'b0;
    fin    = 1'b0;
    case (state)
      ST_IDLE: begin
        n_note = sw;
        if (start && !stop) begin
          nxt    = ST_FETCH;
          n_step = '0;
          n_note = 8'h00;
        end
      end
      ST_FETCH: nxt = ST_DECODE;
      ST_DECODE: begin
        if (dur != 4'd0) begin
          nxt    = ST_PLAY;
          n_note = pitch_onehot(pitch);
          n_rem  = dur;
        end else if (step == '0) begin
          // An empty song finishes even when looping, so it cannot spin
          nxt    = ST_IDLE;
          n_done = 1'b1;
        end else begin
          fin = 1'b1;
        end
      end
      ST_PLAY: begin
        if (tick) begin
          if (rem == 4'd1) begin
            if (GAP_TICKS > 0) begin
              nxt    = ST_GAP;
              n_note = 8'h00;
              n_rem  = 4'(GAP_TICKS);
              clr    = 1'b1;
            end else begin
              adv = 1'b1;
            end
          end else begin
            n_rem = rem - 4'd1;
          end
        end
      end
      ST_GAP: begin
        if (tick) begin
          if (rem == 4'd1)
            adv = 1'b1;
          else
            n_rem = rem - 4'd1;
        end
      end
      default: nxt = ST_IDLE;
    endcase

    if (adv) begin
      if (step == LAST_STEP) begin
        fin = 1'b1;
      end else begin
        n_step = step + 1'b1;
        n_note = 8'h00;
        nxt    = ST_FETCH;
      end
    end

    if (fin) begin
      n_note = 8'h00;
      if (loop) begin
        n_step = '0;
        nxt    = ST_FETCH;
      end else begin
        nxt    = ST_IDLE;
        n_done = 1'b1;
      end
    end

    if (stop && state != ST_IDLE) begin
      nxt    = ST_IDLE;
      n_note = 8'h00;
      n_done = 1'b0;
    end
  end
endmodule
